dm_port_arbiter: RTL and testbench

//  Shares the single-port byte-enabled data RAM between two requesters:
//  m0 = CPU load/store path (post store-decode, lanes replicated, BE set),
//  m1 = secondary master (debug/DMA). Sequences each access, returns read

---
 rtl/dm_port_arbiter.sv | 254 +++++++++++++++++++++++++
 tb/tb_dm_port_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_port_arbiter.sv
// ----------------------------------------------------------------------------
// dm_port_arbiter
//
// Shares one single-port, byte-enabled data RAM between two requesters:
//   m0 : CPU load/store path (lanes already replicated, byte enables set)
//   m1 : secondary master (debug / DMA)
//
// One access is in flight at a time: IDLE -> ACC -> (WAIT x RD_LAT) -> IDLE.
// In IDLE a winner is chosen and its request is registered straight onto the
// RAM-side outputs, so the RAM strobe and the grant pulse appear together in
// the ACC cycle. Reads return ram_rdata on rdata in the cycle the RAM
// delivers it (RD_LAT cycles after ram_en); rdata then holds that value
// until the next read completes.
//
// Byte-enable patterns other than 0000/0001/0010/0100/1000/0011/1100/1111
// are granted (so the requester is released) but never reach the RAM; they
// raise a one-cycle be_err instead.
//
// Build option:
//   DM_ARB_CPU_PRIO_EN  defined     : fixed priority, m0 wins every tie.
//                       not defined : round-robin between m0 and m1.
//
// Parameters:
//   ADDR_W  byte-address width of the requester ports
//   RD_LAT  RAM read latency in cycles (1..3)
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   mX_req/addr/be/wdata       requester X access (be = 0000 means read)
//   mX_gnt                     1-cycle pulse: access for X issued
//   mX_rvalid                  1-cycle pulse: rdata valid for X
//   rdata                      read data (last read value between rvalids)
//   be_err                     1-cycle pulse: granted request had illegal BE
//   ram_en/we/addr/wdata       RAM access strobe, byte writes, word address,
//                              write data
//   ram_rdata                  RAM read data, RD_LAT cycles after ram_en
// ----------------------------------------------------------------------------
module dm_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [3:0]        m0_be,
    input  logic [31:0]       m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [3:0]        m1_be,
    input  logic [31:0]       m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [31:0]       rdata,
    output logic              be_err,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-3:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // WAIT counts down from RD_LAT-1 to 0; the zero cycle is the data cycle.
    localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              id_q, id_d;          // granted master: 0 = m0, 1 = m1
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic              be_err_q, be_err_d;
    logic              ram_en_q, ram_en_d;
    logic [3:0]        ram_we_q, ram_we_d;
    logic [ADDR_W-3:0] ram_addr_q, ram_addr_d;
    logic [31:0]       ram_wdata_q, ram_wdata_d;
    logic [31:0]       rdata_q, rdata_d;
`ifndef DM_ARB_CPU_PRIO_EN
    logic              last_q, last_d;      // last granted master, 1 = m1
`endif

    // ------------------------------------------------------------------
    // Winner selection and request mux
    // ------------------------------------------------------------------
    logic              win_valid;
    logic              win_id;
    logic [ADDR_W-1:0] sel_addr;
    logic [3:0]        sel_be;
    logic [31:0]       sel_wdata;
    logic              sel_legal;
    logic [3:0]        lane_we;
    logic              rvalid_hit;

    always_comb begin
        win_valid = m0_req | m1_req;
`ifdef DM_ARB_CPU_PRIO_EN
        win_id    = ~m0_req;
`else
        // On a tie the master that was not granted last wins.
        if (m0_req && m1_req) begin
            win_id = ~last_q;
        end else begin
            win_id = ~m0_req;
        end
`endif
        sel_addr  = win_id ? m1_addr  : m0_addr;
        sel_be    = win_id ? m1_be    : m0_be;
        sel_wdata = win_id ? m1_wdata : m0_wdata;
    end

    always_comb begin
        sel_legal = 1'b0;
        case (sel_be)
            4'b0000, 4'b0001, 4'b0010, 4'b0100,
            4'b1000, 4'b0011, 4'b1100, 4'b1111: sel_legal = 1'b1;
            default:                            sel_legal = 1'b0;
        endcase
    end

    // Per-lane RAM write enables; an illegal pattern never writes any lane.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane_we
            assign lane_we[gi] = sel_legal & sel_be[gi];
        end
    endgenerate

    // The byte-offset bits do not address the word-wide RAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{m0_addr[1:0], m1_addr[1:0]};

    // ------------------------------------------------------------------
    // Read return: gated by reset so a read cut off by reset never returns.
    // ------------------------------------------------------------------
    assign rvalid_hit = (state_q == ST_WAIT) && (cnt_q == 2'd0) && !reset;

    assign m0_rvalid = rvalid_hit & ~id_q;
    assign m1_rvalid = rvalid_hit &  id_q;
    assign rdata     = rvalid_hit ? ram_rdata : rdata_q;

    assign m0_gnt    = gnt0_q;
    assign m1_gnt    = gnt1_q;
    assign be_err    = be_err_q;
    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        id_d        = id_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        be_err_d    = 1'b0;
        ram_en_d    = 1'b0;
        ram_we_d    = 4'b0000;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        rdata_d     = rvalid_hit ? ram_rdata : rdata_q;
`ifndef DM_ARB_CPU_PRIO_EN
        last_d      = last_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    state_d     = ST_ACC;
                    id_d        = win_id;
                    gnt0_d      = ~win_id;
                    gnt1_d      =  win_id;
                    ram_addr_d  = sel_addr[ADDR_W-1:2];
                    ram_wdata_d = sel_wdata;
                    ram_en_d    = sel_legal;
                    ram_we_d    = lane_we;
                    be_err_d    = ~sel_legal;
`ifndef DM_ARB_CPU_PRIO_EN
                    // Illegal-BE grants also move the pointer.
                    last_d      = win_id;
`endif
                end
            end

            ST_ACC: begin
                // Only a legal read (strobe on, no lane written) waits for data.
                cnt_d = WAIT_INIT;
                if (ram_en_q && (ram_we_q == 4'b0000)) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 2'd0;
            id_q        <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            be_err_q    <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 4'b0000;
            ram_addr_q  <= '0;
            ram_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
`ifndef DM_ARB_CPU_PRIO_EN
            last_q      <= 1'b1;    // m1 "last", so m0 wins the first tie
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            id_q        <= id_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            be_err_q    <= be_err_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            rdata_q     <= rdata_d;
`ifndef DM_ARB_CPU_PRIO_EN
            last_q      <= last_d;
`endif
        end
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dm_port_arbiter
//
// Directed scenarios followed by a randomized run. A transaction-level model
// decides, from the arbitration rules, which master is granted when and
// schedules the expected per-cycle outputs into a small ring indexed by the
// absolute cycle number. Every cycle the DUT outputs are compared with that
// schedule. The RAM read data is a fresh random word per cycle.
// ----------------------------------------------------------------------------
module tb_dm_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int RD_LAT = 2;
    localparam int RING   = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              m0_req, m1_req;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic [3:0]        m0_be, m1_be;
    logic [31:0]       m0_wdata, m1_wdata;
    logic              m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0]       rdata;
    logic              be_err, ram_en;
    logic [3:0]        ram_we;
    logic [ADDR_W-3:0] ram_addr;
    logic [31:0]       ram_wdata, ram_rdata;

    always #5 clk = ~clk;

    dm_port_arbiter #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_addr   (m0_addr),
        .m0_be     (m0_be),
        .m0_wdata  (m0_wdata),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m1_req    (m1_req),
        .m1_addr   (m1_addr),
        .m1_be     (m1_be),
        .m1_wdata  (m1_wdata),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .rdata     (rdata),
        .be_err    (be_err),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    typedef struct {
        bit        gnt0, gnt1, err, en, rv0, rv1;
        bit [3:0]  we;
        bit [29:0] addr;
        bit [31:0] wdata;
    } exp_t;

    exp_t        sched [RING];
    int          ncmp = 0;
    int          nerr = 0;
    int          cyc = 0;
    int          busy_until = 0;
    bit          last_m1 = 1'b1;
    logic [31:0] hold = 32'd0;
    bit          post_rst = 1'b0;
    bit          chk_en = 1'b0;
    bit          use_fixed = 1'b0;
    logic [31:0] fixed_val = 32'd0;

    // Requester intent (model side); cleared when the model grants it.
    bit          a0 = 1'b0, a1 = 1'b0;
    logic [31:0] ad0 = 32'd0, ad1 = 32'd0, w0 = 32'd0, w1 = 32'd0;
    logic [3:0]  b0 = 4'd0, b1 = 4'd0;

    function automatic bit be_ok(input logic [3:0] be);
        return be inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs, advance the model.
    task automatic step(input bit rst);
        int          k;
        int          n;
        exp_t        e;
        bit          w;
        bit          rv0;
        bit          rv1;
        logic [3:0]  be;
        logic [31:0] ad;
        logic [31:0] rd_val;

        rd_val    = use_fixed ? fixed_val : $urandom;
        reset     = rst;
        m0_req    = a0;  m0_addr = ad0;  m0_be = b0;  m0_wdata = w0;
        m1_req    = a1;  m1_addr = ad1;  m1_be = b1;  m1_wdata = w1;
        ram_rdata = rd_val;
        #1;

        k   = cyc % RING;
        e   = sched[k];
        rv0 = e.rv0 && !rst;
        rv1 = e.rv1 && !rst;
        if (chk_en) begin
            chk("m0_gnt",    32'(m0_gnt),    32'(e.gnt0));
            chk("m1_gnt",    32'(m1_gnt),    32'(e.gnt1));
            chk("be_err",    32'(be_err),    32'(e.err));
            chk("ram_en",    32'(ram_en),    32'(e.en));
            chk("ram_we",    32'(ram_we),    32'(e.we));
            chk("m0_rvalid", 32'(m0_rvalid), 32'(rv0));
            chk("m1_rvalid", 32'(m1_rvalid), 32'(rv1));
            chk("rdata",     rdata,          (rv0 || rv1) ? rd_val : hold);
            if (e.en) chk("ram_addr", 32'(ram_addr), 32'(e.addr));
            if (e.en && e.we != 4'd0) chk("ram_wdata", ram_wdata, e.wdata);
            if (post_rst) begin
                chk("rst_ram_addr",  32'(ram_addr), 32'd0);
                chk("rst_ram_wdata", ram_wdata,     32'd0);
            end
        end
        if (rv0 || rv1) hold = rd_val;
        sched[k] = '{default: 0};
        post_rst = 1'b0;

        if (rst) begin
            foreach (sched[j]) sched[j] = '{default: 0};
            busy_until = cyc + 1;
            last_m1    = 1'b1;
            hold       = 32'd0;
            post_rst   = 1'b1;
            chk_en     = 1'b1;
        end else if (cyc >= busy_until && (a0 || a1)) begin
`ifdef DM_ARB_CPU_PRIO_EN
            w = a0 ? 1'b0 : 1'b1;
`else
            w = (a0 && a1) ? !last_m1 : !a0;
`endif
            be = w ? b1 : b0;
            ad = w ? ad1 : ad0;
            n  = (cyc + 1) % RING;
            if (w) sched[n].gnt1 = 1'b1;
            else   sched[n].gnt0 = 1'b1;
            if (be_ok(be)) begin
                sched[n].en    = 1'b1;
                sched[n].we    = be;
                sched[n].addr  = ad[31:2];
                sched[n].wdata = w ? w1 : w0;
                if (be == 4'd0) begin
                    if (w) sched[(cyc + 1 + RD_LAT) % RING].rv1 = 1'b1;
                    else   sched[(cyc + 1 + RD_LAT) % RING].rv0 = 1'b1;
                    busy_until = cyc + 2 + RD_LAT;
                end else begin
                    busy_until = cyc + 2;
                end
            end else begin
                sched[n].err = 1'b1;
                busy_until   = cyc + 2;
            end
            last_m1 = w;
            $display("txn cyc=%0d m%0d %s be=%b addr=%h", cyc, w,
                     be_ok(be) ? ((be == 4'd0) ? "read " : "write") : "badbe", be, ad);
            if (w) a1 = 1'b0;
            else   a0 = 1'b0;
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_idle_reqs();
        for (int i = 0; i < 20 && (a0 || a1); i++) step(1'b0);
        chk("grant_timeout", 32'({a0, a1}), 32'd0);
    endtask

    initial begin
        // Reset
        step(1'b1);
        step(1'b1);

        // m0 write: addr 0x10, be 0011
        a0 = 1'b1; ad0 = 32'h10; b0 = 4'b0011; w0 = 32'hBEEF_BEEF;
        wait_idle_reqs();
        repeat (3) step(1'b0);

        // m1 read: addr 0x20, fixed RAM data
        use_fixed = 1'b1; fixed_val = 32'h1234_5678;
        a1 = 1'b1; ad1 = 32'h20; b1 = 4'b0000;
        wait_idle_reqs();
        repeat (4) step(1'b0);
        use_fixed = 1'b0;

        // Both masters reading continuously from reset
        step(1'b1);
        for (int i = 0; i < 16; i++) begin
            if (!a0) begin a0 = 1'b1; ad0 = 32'h100 + 32'(i * 4); b0 = 4'd0; end
            if (!a1) begin a1 = 1'b1; ad1 = 32'h200 + 32'(i * 4); b1 = 4'd0; end
            step(1'b0);
        end
        a0 = 1'b0; a1 = 1'b0;
        repeat (4) step(1'b0);

        // Illegal byte enable
        a0 = 1'b1; ad0 = 32'h44; b0 = 4'b0101; w0 = 32'hA5A5_A5A5;
        wait_idle_reqs();
        repeat (3) step(1'b0);

        // Reset while an m0 read is in WAIT, then a tie
        a0 = 1'b1; ad0 = 32'h40; b0 = 4'd0;
        wait_idle_reqs();
        step(1'b0);                 // ACC
        step(1'b1);                 // first WAIT cycle with reset
        a0 = 1'b1; ad0 = 32'h80; b0 = 4'd0;
        a1 = 1'b1; ad1 = 32'h84; b1 = 4'd0;
        wait_idle_reqs();
        repeat (5) step(1'b0);

        // Randomized traffic with occasional drops and resets
        for (int i = 0; i < 1200; i++) begin
            if (!a0) begin
                if ($urandom_range(0, 1) == 0) begin
                    a0  = 1'b1; ad0 = $urandom; w0 = $urandom;
                    b0  = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
                end
            end else if ($urandom_range(0, 19) == 0) begin
                a0 = 1'b0;
            end
            if (!a1) begin
                if ($urandom_range(0, 1) == 0) begin
                    a1  = 1'b1; ad1 = $urandom; w1 = $urandom;
                    b1  = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
                end
            end else if ($urandom_range(0, 19) == 0) begin
                a1 = 1'b0;
            end
            step($urandom_range(0, 199) == 0);
        end
        a0 = 1'b0; a1 = 1'b0;
        repeat (6) step(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
